cla_pipe: RTL

- Parametrised, pipelined carry-lookahead adder/subtractor. Successor to the single-cycle 32-bit CLA.
- Splits a WIDTH-bit operation into STAGES equal slices, one slice per pipeline stage, with the carry registered between stages.
- Valid/ready handshake on both sides. Full throughput: one operation per cycle.
- Sits between the execute-stage operand muxes and writeback in the pipelined datapath; also usable as a standalone arithmetic unit.

---
 rtl/cla_pkg.sv | 25 ++
 rtl/cla_slice.sv | 59 +++++
 rtl/cla_pipe.sv | 126 ++++++++++++
 3 files changed

// File: rtl/cla_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead adder (cla_pipe).
package cla_pkg;

  localparam int unsigned CLA_DEFAULT_WIDTH  = 32;
  localparam int unsigned CLA_DEFAULT_STAGES = 4;
  localparam int unsigned CLA_GROUP_W        = 4;
  localparam int unsigned CLA_MAX_WIDTH      = 1024;

  function automatic int unsigned slice_w(input int unsigned width, input int unsigned stages);
    return width / stages;
  endfunction

  // Saturation pattern in the low `width` bits: 0111..1 for positive, 1000..0 for negative.
  function automatic logic [CLA_MAX_WIDTH-1:0] sat_value(input logic negative,
                                                         input int unsigned width);
    logic [CLA_MAX_WIDTH-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < CLA_MAX_WIDTH; i++) begin
      if (i + 1 < width)       v[i] = ~negative;
      else if (i + 1 == width) v[i] = negative;
    end
    return v;
  endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational W-bit carry-lookahead slice built from 4-bit generate/propagate groups.
module cla_slice
  import cla_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         cmsb
);

  localparam int unsigned NG = (W + CLA_GROUP_W - 1) / CLA_GROUP_W;
  localparam int unsigned PW = NG * CLA_GROUP_W;

  logic [PW-1:0] g, p, c;
  logic [NG-1:0] grp_g, grp_p;
  logic [NG:0]   grp_c;
  logic          run;

  always_comb begin
    // Padding bits propagate so a partial top group passes its carry through.
    g = '0;
    p = '1;
    g[W-1:0] = a & b;
    p[W-1:0] = a ^ b;
    run = 1'b0;
    c = '0;

    for (int unsigned j = 0; j < NG; j++) begin
      grp_g[j] = 1'b0;
      grp_p[j] = 1'b1;
      for (int unsigned i = 0; i < CLA_GROUP_W; i++) begin
        grp_g[j] = g[j*CLA_GROUP_W + i] | (p[j*CLA_GROUP_W + i] & grp_g[j]);
        grp_p[j] = grp_p[j] & p[j*CLA_GROUP_W + i];
      end
    end

    grp_c[0] = cin;
    for (int unsigned j = 0; j < NG; j++) begin
      grp_c[j+1] = grp_g[j] | (grp_p[j] & grp_c[j]);
    end

    for (int unsigned j = 0; j < NG; j++) begin
      run = grp_c[j];
      for (int unsigned i = 0; i < CLA_GROUP_W; i++) begin
        c[j*CLA_GROUP_W + i] = run;
        run = g[j*CLA_GROUP_W + i] | (p[j*CLA_GROUP_W + i] & run);
      end
    end

    sum  = p[W-1:0] ^ c[W-1:0];
    cout = grp_c[NG];
    cmsb = c[W-1];
  end

endmodule

// File: rtl/cla_pipe.sv
// Pipelined carry-lookahead adder/subtractor, one WIDTH/STAGES-bit slice per stage.
// Define CLA_PIPE_SAT_EN to saturate out_sum on signed overflow.
module cla_pipe
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH  = CLA_DEFAULT_WIDTH,
  parameter int unsigned STAGES = CLA_DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int unsigned S = slice_w(WIDTH, STAGES);
  localparam int unsigned L = STAGES - 1;

`ifdef CLA_PIPE_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  localparam logic [CLA_MAX_WIDTH-1:0] SAT_POS_FULL = sat_value(1'b0, WIDTH);
  localparam logic [CLA_MAX_WIDTH-1:0] SAT_NEG_FULL = sat_value(1'b1, WIDTH);
  localparam logic [WIDTH-1:0]         SAT_POS      = SAT_POS_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0]         SAT_NEG      = SAT_NEG_FULL[WIDTH-1:0];

  typedef struct packed {
    logic             valid;
    logic             carry;
    logic             msb_carry;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] a_rem;
    logic [WIDTH-1:0] b_rem;
  } stage_t;

  stage_t st  [STAGES];
  stage_t src [STAGES];
  stage_t nxt [STAGES];

  logic [STAGES-1:0]        ld;
  logic [STAGES-1:0][S-1:0] sl_a, sl_b, sl_sum;
  logic [STAGES-1:0]        sl_cin, sl_cout, sl_cmsb;

  // Ready ripples backwards so a draining stage can refill in the same cycle.
  always_comb begin
    ld = '0;
    ld[L] = ~st[L].valid | out_ready;
    for (int unsigned k = L; k > 0; k--) begin
      ld[k-1] = ~st[k-1].valid | ld[k];
    end
  end

  assign in_ready = ld[0];

  always_comb begin
    src[0]       = '0;
    src[0].valid = in_valid;
    src[0].carry = in_sub | in_cin;
    src[0].a_rem = in_a;
    src[0].b_rem = in_sub ? ~in_b : in_b;
    for (int unsigned k = 1; k < STAGES; k++) begin
      src[k] = st[k-1];
    end
    for (int unsigned k = 0; k < STAGES; k++) begin
      sl_a[k]   = src[k].a_rem[k*S +: S];
      sl_b[k]   = src[k].b_rem[k*S +: S];
      sl_cin[k] = src[k].carry;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    cla_slice #(.W(S)) u_slice (
      .a    (sl_a[k]),
      .b    (sl_b[k]),
      .cin  (sl_cin[k]),
      .sum  (sl_sum[k]),
      .cout (sl_cout[k]),
      .cmsb (sl_cmsb[k])
    );
  end

  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      nxt[k]                 = src[k];
      nxt[k].carry           = sl_cout[k];
      nxt[k].msb_carry       = sl_cmsb[k];
      nxt[k].sum[k*S +: S]   = sl_sum[k];
    end
    // On overflow both operands share a sign, so A's MSB picks the saturation direction.
    if (SAT_EN && (sl_cout[L] ^ sl_cmsb[L])) begin
      nxt[L].sum = nxt[L].a_rem[WIDTH-1] ? SAT_NEG : SAT_POS;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        st[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (ld[k]) begin
          if (src[k].valid) st[k]       <= nxt[k];
          else              st[k].valid <= 1'b0;
        end
      end
    end
  end

  assign out_valid = st[L].valid;
  assign out_sum   = st[L].sum;
  assign out_cout  = st[L].carry;
  assign out_ovf   = st[L].carry ^ st[L].msb_carry;

endmodule
